// File: rtl/gate_chk_pkg.sv
// ---------------------------------------------------------------------------
// gate_chk_pkg
//
// Shared definitions for the gate sweep checker and its helpers:
//   - chk_state_e : sweep FSM state encoding (IDLE, SETTLE, SAMPLE, DONE)
//   - TT_*        : canonical 2-input truth tables, bit i is the expected
//                   output for input vector i ({a,b} with a as the MSB)
//   - timer_width : counter width needed to count from 0 to settle-1
// ---------------------------------------------------------------------------
package gate_chk_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } chk_state_e;

   localparam logic [3:0] TT_AND  = 4'b1000;
   localparam logic [3:0] TT_NAND = 4'b0111;
   localparam logic [3:0] TT_OR   = 4'b1110;
   localparam logic [3:0] TT_NOR  = 4'b0001;
   localparam logic [3:0] TT_XOR  = 4'b0110;

   // A settle count of one still needs a one-bit counter so that the
   // expiry compare has something to look at.
   function automatic int unsigned timer_width(input int unsigned settle);
      return (settle > 1) ? $clog2(settle) : 1;
   endfunction

endpackage

// File: rtl/gate_sweep_checker_settle_timer.sv
// ---------------------------------------------------------------------------
// settle_timer
//
// Up-counter that measures how long the current input vector has been
// applied to the gate under test.
//
// Ports:
//   clk     : rising-edge clock
//   rst_n   : synchronous active-low reset, counter returns to zero
//   clr     : reload the counter to zero (wins over en)
//   en      : advance the counter by one
//   expired : counter currently holds SETTLE-1
// ---------------------------------------------------------------------------
module settle_timer
   import gate_chk_pkg::*;
#(
   parameter int unsigned SETTLE = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int unsigned CW = timer_width(SETTLE);
   localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Next count: a clear always returns to zero so every vector starts its
   // settle interval from the same point; otherwise count while enabled.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Counter register with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Expiry is a plain compare against the last settle cycle.
   assign expired = (cnt_q == LAST);

endmodule

// File: rtl/gate_sweep_checker.sv
// ---------------------------------------------------------------------------
// gate_sweep_checker
//
// Clocked stimulus-and-check stage for a combinational gate. After a start
// it walks dut_in through every input combination in ascending order, lets
// each vector settle for SETTLE cycles, samples dut_y once, and compares the
// sample against the truth table latched at start. Results hold until the
// next accepted start.
//
// Parameters:
//   N_IN   : number of gate inputs (1..4)
//   SETTLE : settle cycles per vector before the sample (>= 1)
//
// Ports:
//   clk              : rising-edge clock
//   rst_n            : synchronous active-low reset, clears every output
//   start            : begin a sweep, only honoured while idle
//   tt_expected      : expected truth table, bit i is y for dut_in == i
//   dut_y            : output of the gate under test
//   dut_in           : gate inputs, MSB is the first operand
//   busy             : sweep in progress (start acceptance through DONE)
//   done             : one-cycle pulse when the sweep finishes
//   pass             : no mismatches in the last sweep
//   err_count        : number of mismatching vectors in the last sweep
//   first_fail_vec   : lowest mismatching vector index
//   first_fail_valid : first_fail_vec holds a real mismatch
//   observed_tt      : sampled dut_y for every vector
// ---------------------------------------------------------------------------
module gate_sweep_checker
   import gate_chk_pkg::*;
#(
   parameter int unsigned N_IN   = 2,
   parameter int unsigned SETTLE = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [2**N_IN-1:0]   tt_expected,
   input  logic                 dut_y,
   output logic [N_IN-1:0]      dut_in,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [N_IN:0]        err_count,
   output logic [N_IN-1:0]      first_fail_vec,
   output logic                 first_fail_valid,
   output logic [2**N_IN-1:0]   observed_tt
);

   localparam int unsigned NV = 2**N_IN;
   localparam logic [N_IN-1:0] LAST_VEC = N_IN'(NV - 1);

   chk_state_e        state_q;
   chk_state_e        state_d;
   logic [N_IN-1:0]   vec_q;
   logic [N_IN-1:0]   vec_d;
   logic [NV-1:0]     tt_q;
   logic [NV-1:0]     tt_d;
   logic [NV-1:0]     observed_q;
   logic [NV-1:0]     observed_d;
   logic [N_IN:0]     err_q;
   logic [N_IN:0]     err_d;
   logic [N_IN-1:0]   first_vec_q;
   logic [N_IN-1:0]   first_vec_d;
   logic              first_valid_q;
   logic              first_valid_d;
   logic              pass_q;
   logic              pass_d;
   logic              busy_q;
   logic              busy_d;
   logic              done_q;
   logic              done_d;

   logic              timer_clr;
   logic              timer_en;
   logic              timer_expired;
   logic              mismatch;
   logic [N_IN:0]     err_next;

   // Settle interval timer. It is held at zero outside SETTLE so that each
   // vector's interval begins fresh, and it stops at its last value so it
   // never wraps while the FSM is leaving SETTLE.
   settle_timer #(
      .SETTLE (SETTLE)
   ) u_settle_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (timer_clr),
      .en      (timer_en),
      .expired (timer_expired)
   );

   // Timer control follows directly from the current state.
   always_comb begin
      timer_clr = (state_q != ST_SETTLE);
      timer_en  = (state_q == ST_SETTLE) && !timer_expired;
   end

   // Compare the live gate output with the latched expectation for the
   // current vector, and form the error count including this vector. The
   // count is one bit wider than the vector so a fully wrong gate fits.
   always_comb begin
      mismatch = (dut_y != tt_q[vec_q]);
      err_next = err_q + {{N_IN{1'b0}}, mismatch};
   end

   // Sweep FSM next-state and result logic. Every output is a register, so
   // this block decides what each register holds after the coming edge.
   // The pass flag is resolved on the way into DONE using the count that
   // includes the final vector, so it is already valid during the done
   // pulse. The vector register doubles as the dut_in drive, which means
   // dut_in only moves at start and when SAMPLE hands over to SETTLE.
   always_comb begin
      state_d       = state_q;
      vec_d         = vec_q;
      tt_d          = tt_q;
      observed_d    = observed_q;
      err_d         = err_q;
      first_vec_d   = first_vec_q;
      first_valid_d = first_valid_q;
      pass_d        = pass_q;
      busy_d        = busy_q;
      done_d        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            busy_d = 1'b0;
            if (start) begin
               tt_d          = tt_expected;
               vec_d         = '0;
               observed_d    = '0;
               err_d         = '0;
               first_vec_d   = '0;
               first_valid_d = 1'b0;
               pass_d        = 1'b0;
               busy_d        = 1'b1;
               state_d       = ST_SETTLE;
            end
         end

         ST_SETTLE: begin
            if (timer_expired) begin
               state_d = ST_SAMPLE;
            end
         end

         ST_SAMPLE: begin
            observed_d[vec_q] = dut_y;
            err_d             = err_next;
            if (mismatch && !first_valid_q) begin
               first_vec_d   = vec_q;
               first_valid_d = 1'b1;
            end
            if (vec_q == LAST_VEC) begin
               done_d  = 1'b1;
               pass_d  = (err_next == '0);
               state_d = ST_DONE;
            end else begin
               vec_d   = vec_q + N_IN'(1);
               state_d = ST_SETTLE;
            end
         end

         ST_DONE: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end

         default: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and result registers. Reset wins over everything, discarding any
   // partial sweep without producing a done pulse.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         vec_q         <= '0;
         tt_q          <= '0;
         observed_q    <= '0;
         err_q         <= '0;
         first_vec_q   <= '0;
         first_valid_q <= 1'b0;
         pass_q        <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         vec_q         <= vec_d;
         tt_q          <= tt_d;
         observed_q    <= observed_d;
         err_q         <= err_d;
         first_vec_q   <= first_vec_d;
         first_valid_q <= first_valid_d;
         pass_q        <= pass_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
      end
   end

   // Outputs come straight from registers.
   assign dut_in           = vec_q;
   assign busy             = busy_q;
   assign done             = done_q;
   assign pass             = pass_q;
   assign err_count        = err_q;
   assign first_fail_vec   = first_vec_q;
   assign first_fail_valid = first_valid_q;
   assign observed_tt      = observed_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// ---------------------------------------------------------------------------
// tb_gate_sweep_checker
//
// Bench for gate_sweep_checker. A default instance (2 inputs, settle 2) and
// a 3-input instance (settle 1) each drive a behavioural gate whose truth
// table is a bench variable. Expected results are worked out from the two
// truth tables directly: the mismatches are the bits where they differ, the
// first failure is the lowest such bit, and the vector applied at cycle t
// after acceptance is t / (SETTLE+1).
// ---------------------------------------------------------------------------
module tb_gate_sweep_checker;
   import gate_chk_pkg::*;

   localparam int SETTLE2 = 2;
   localparam int SETTLE3 = 1;

   logic       clk;
   logic       rst_n;

   logic       start;
   logic [3:0] tt_expected;
   logic [3:0] gate_tt;
   logic       dut_y;
   logic [1:0] dut_in;
   logic       busy;
   logic       done;
   logic       pass;
   logic [2:0] err_count;
   logic [1:0] first_fail_vec;
   logic       first_fail_valid;
   logic [3:0] observed_tt;

   logic       start3;
   logic [7:0] tt_expected3;
   logic [7:0] gate_tt3;
   logic       dut_y3;
   logic [2:0] dut_in3;
   logic       busy3;
   logic       done3;
   logic       pass3;
   logic [3:0] err_count3;
   logic [2:0] first_fail_vec3;
   logic       first_fail_valid3;
   logic [7:0] observed_tt3;

   int tests;
   int fails;

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural gates under test: a table lookup on the applied vector.
   assign dut_y  = gate_tt[dut_in];
   assign dut_y3 = gate_tt3[dut_in3];

   gate_sweep_checker #(
      .N_IN   (2),
      .SETTLE (SETTLE2)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .start            (start),
      .tt_expected      (tt_expected),
      .dut_y            (dut_y),
      .dut_in           (dut_in),
      .busy             (busy),
      .done             (done),
      .pass             (pass),
      .err_count        (err_count),
      .first_fail_vec   (first_fail_vec),
      .first_fail_valid (first_fail_valid),
      .observed_tt      (observed_tt)
   );

   gate_sweep_checker #(
      .N_IN   (3),
      .SETTLE (SETTLE3)
   ) dut3 (
      .clk              (clk),
      .rst_n            (rst_n),
      .start            (start3),
      .tt_expected      (tt_expected3),
      .dut_y            (dut_y3),
      .dut_in           (dut_in3),
      .busy             (busy3),
      .done             (done3),
      .pass             (pass3),
      .err_count        (err_count3),
      .first_fail_vec   (first_fail_vec3),
      .first_fail_valid (first_fail_valid3),
      .observed_tt      (observed_tt3)
   );

   // Advance one clock and step just past the edge so outputs are stable.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a gate, an expected table and a start request.
   task automatic applyStimulus(input logic [3:0] exp_tt, input logic [3:0] gtt);
      gate_tt     = gtt;
      tt_expected = exp_tt;
      start       = 1'b1;
   endtask

   // One full sweep on the default instance with the results checked against
   // the truth-table model. With disturb set, tt_expected and start are
   // scrambled during the sweep; neither may affect the outcome.
   task automatic run_sweep(input logic [3:0] exp_tt, input logic [3:0] gtt,
                            input bit disturb, input string name);
      logic [3:0] diff;
      int         errs;
      int         first;
      bit         seq_ok;
      bit         seen;
      int         t;
      logic [3:0] err_snap;

      diff  = exp_tt ^ gtt;
      errs  = 0;
      first = 0;
      for (int i = 3; i >= 0; i--) begin
         if (diff[i]) begin
            errs++;
            first = i;
         end
      end

      applyStimulus(exp_tt, gtt);
      tick();
      start = 1'b0;

      tests++;
      if (busy !== 1'b1 || dut_in !== 2'd0) begin
         fails++;
         $display("[TB] FAIL %s accept: busy=%b dut_in=%0d, required busy=1 dut_in=0",
                  name, busy, dut_in);
      end

      seq_ok = 1'b1;
      seen   = 1'b0;
      t      = 0;
      while (!seen && t < 40) begin
         if (done === 1'b1) begin
            seen = 1'b1;
         end else begin
            if (dut_in !== 2'(t / (SETTLE2 + 1)) || busy !== 1'b1) seq_ok = 1'b0;
            if (disturb) begin
               tt_expected = 4'($urandom);
               start       = 1'($urandom_range(0, 1));
            end
            tick();
            t++;
         end
      end
      start = 1'b0;

      tests++;
      if (!seen || t != 4 * (SETTLE2 + 1)) begin
         fails++;
         $display("[TB] FAIL %s done_latency: got %0d cycles (seen=%0b), required %0d",
                  name, t, seen, 4 * (SETTLE2 + 1));
      end
      tests++;
      if (!seq_ok) begin
         fails++;
         $display("[TB] FAIL %s vector_sequence: dut_in/busy deviated from 0,1,2,3 at %0d cycles each",
                  name, SETTLE2 + 1);
      end
      tests++;
      if (err_count !== 3'(errs)) begin
         fails++;
         $display("[TB] FAIL %s err_count: got %0d, required %0d", name, err_count, errs);
      end
      tests++;
      if (pass !== (errs == 0)) begin
         fails++;
         $display("[TB] FAIL %s pass: got %b, required %b", name, pass, errs == 0);
      end
      tests++;
      if (observed_tt !== gtt) begin
         fails++;
         $display("[TB] FAIL %s observed_tt: got %b, required %b", name, observed_tt, gtt);
      end
      tests++;
      if (first_fail_valid !== (errs != 0)) begin
         fails++;
         $display("[TB] FAIL %s first_fail_valid: got %b, required %b",
                  name, first_fail_valid, errs != 0);
      end
      if (errs != 0) begin
         tests++;
         if (first_fail_vec !== 2'(first)) begin
            fails++;
            $display("[TB] FAIL %s first_fail_vec: got %0d, required %0d",
                     name, first_fail_vec, first);
         end
      end

      err_snap = {1'b0, err_count};
      tick();
      tests++;
      if (done !== 1'b0 || busy !== 1'b0 || {1'b0, err_count} !== 4'(errs)) begin
         fails++;
         $display("[TB] FAIL %s after_done: done=%b busy=%b err_count=%0d (at done %0d), required 0 0 %0d",
                  name, done, busy, err_count, err_snap, errs);
      end
   endtask

   // After reset every output of both instances must be zero.
   task automatic test_reset();
      rst_n  = 1'b0;
      start  = 1'b1;
      start3 = 1'b1;
      tick();
      tick();
      tests++;
      if ({dut_in, busy, done, pass, err_count, first_fail_vec, first_fail_valid, observed_tt} !== '0) begin
         fails++;
         $display("[TB] FAIL reset_outputs: got %b, required all zero",
                  {dut_in, busy, done, pass, err_count, first_fail_vec, first_fail_valid, observed_tt});
      end
      tests++;
      if ({dut_in3, busy3, done3, pass3, err_count3, first_fail_vec3, first_fail_valid3, observed_tt3} !== '0) begin
         fails++;
         $display("[TB] FAIL reset_outputs3: got %b, required all zero",
                  {dut_in3, busy3, done3, pass3, err_count3, first_fail_vec3, first_fail_valid3, observed_tt3});
      end
      start  = 1'b0;
      start3 = 1'b0;
      rst_n  = 1'b1;
      tick();
   endtask

   // Known gates from the test plan.
   task automatic test_known_gates();
      run_sweep(TT_AND, TT_AND, 1'b0, "and_pass");
      run_sweep(TT_NAND, TT_AND, 1'b0, "and_vs_nand");
      run_sweep(TT_AND, 4'b1111, 1'b0, "stuck_high");
      run_sweep(TT_XOR, TT_OR, 1'b0, "or_vs_xor");
   endtask

   // Random gate/expectation pairs, half of them with inputs scrambled
   // mid-sweep.
   task automatic test_random();
      for (int r = 0; r < 8; r++) begin
         run_sweep(4'($urandom), 4'($urandom), r[0], $sformatf("random%0d", r));
      end
   endtask

   // Reset applied six edges into a sweep discards it without a done pulse,
   // and a fresh sweep afterwards completes normally.
   task automatic test_reset_mid_sweep();
      bit stray_done;
      run_sweep(TT_NAND, TT_AND, 1'b0, "pre_reset");
      applyStimulus(TT_NOR, TT_AND);
      tick();
      start = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tests++;
      if ({dut_in, busy, done, pass, err_count, first_fail_vec, first_fail_valid, observed_tt} !== '0) begin
         fails++;
         $display("[TB] FAIL mid_reset_outputs: got %b, required all zero",
                  {dut_in, busy, done, pass, err_count, first_fail_vec, first_fail_valid, observed_tt});
      end
      stray_done = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (done !== 1'b0 || busy !== 1'b0) stray_done = 1'b1;
         tick();
      end
      tests++;
      if (stray_done) begin
         fails++;
         $display("[TB] FAIL mid_reset_quiet: got done/busy activity after reset, required none");
      end
      run_sweep(TT_AND, TT_AND, 1'b0, "post_reset");
   endtask

   // Start held high: the next sweep is accepted after exactly one idle
   // cycle following done.
   task automatic test_back_to_back();
      int t;
      bit seen;
      applyStimulus(TT_AND, TT_AND);
      tick();
      seen = 1'b0;
      t    = 0;
      while (!seen && t < 40) begin
         if (done === 1'b1) seen = 1'b1;
         else begin
            tick();
            t++;
         end
      end
      tests++;
      if (!seen || t != 12) begin
         fails++;
         $display("[TB] FAIL b2b_first_done: got %0d cycles (seen=%0b), required 12", t, seen);
      end
      tick();
      tests++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         fails++;
         $display("[TB] FAIL b2b_idle_gap: busy=%b done=%b, required 0 0", busy, done);
      end
      tick();
      tests++;
      if (busy !== 1'b1 || dut_in !== 2'd0) begin
         fails++;
         $display("[TB] FAIL b2b_reaccept: busy=%b dut_in=%0d, required 1 0", busy, dut_in);
      end
      start = 1'b0;
      seen  = 1'b0;
      t     = 0;
      while (!seen && t < 40) begin
         if (done === 1'b1) seen = 1'b1;
         else begin
            tick();
            t++;
         end
      end
      tests++;
      if (!seen || t != 12 || pass !== 1'b1) begin
         fails++;
         $display("[TB] FAIL b2b_second_done: got %0d cycles (seen=%0b) pass=%b, required 12 pass=1",
                  t, seen, pass);
      end
      tick();
      tick();
      tests++;
      if (busy !== 1'b0) begin
         fails++;
         $display("[TB] FAIL b2b_no_third: busy=%b, required 0", busy);
      end
   endtask

   // Three-input instance: AND must pass in 16 cycles, then a random pair.
   task automatic test_three_input();
      logic [7:0] exp_tt;
      logic [7:0] gtt;
      logic [7:0] diff;
      int         errs;
      int         first;
      int         t;
      bit         seen;
      bit         seq_ok;
      for (int r = 0; r < 2; r++) begin
         if (r == 0) begin
            exp_tt = 8'b1000_0000;
            gtt    = 8'b1000_0000;
         end else begin
            exp_tt = 8'($urandom);
            gtt    = 8'($urandom);
         end
         diff  = exp_tt ^ gtt;
         errs  = 0;
         first = 0;
         for (int i = 7; i >= 0; i--) begin
            if (diff[i]) begin
               errs++;
               first = i;
            end
         end
         gate_tt3     = gtt;
         tt_expected3 = exp_tt;
         start3       = 1'b1;
         tick();
         start3 = 1'b0;
         seen   = 1'b0;
         seq_ok = 1'b1;
         t      = 0;
         while (!seen && t < 60) begin
            if (done3 === 1'b1) seen = 1'b1;
            else begin
               if (dut_in3 !== 3'(t / (SETTLE3 + 1)) || busy3 !== 1'b1) seq_ok = 1'b0;
               tick();
               t++;
            end
         end
         tests++;
         if (!seen || t != 8 * (SETTLE3 + 1) || !seq_ok) begin
            fails++;
            $display("[TB] FAIL n3_timing%0d: got %0d cycles (seen=%0b seq_ok=%0b), required 16",
                     r, t, seen, seq_ok);
         end
         tests++;
         if (err_count3 !== 4'(errs) || pass3 !== (errs == 0) || observed_tt3 !== gtt) begin
            fails++;
            $display("[TB] FAIL n3_results%0d: err=%0d pass=%b obs=%b, required %0d %b %b",
                     r, err_count3, pass3, observed_tt3, errs, errs == 0, gtt);
         end
         tests++;
         if (first_fail_valid3 !== (errs != 0) || (errs != 0 && first_fail_vec3 !== 3'(first))) begin
            fails++;
            $display("[TB] FAIL n3_first_fail%0d: valid=%b vec=%0d, required %b %0d",
                     r, first_fail_valid3, first_fail_vec3, errs != 0, first);
         end
         tick();
      end
   endtask

   // Scenario sequence and summary.
   initial begin
      tests        = 0;
      fails        = 0;
      rst_n        = 1'b0;
      start        = 1'b0;
      start3       = 1'b0;
      tt_expected  = '0;
      gate_tt      = '0;
      tt_expected3 = '0;
      gate_tt3     = '0;

      test_reset();
      test_known_gates();
      test_random();
      test_reset_mid_sweep();
      test_back_to_back();
      test_three_input();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/gate_sweep_checker.md
# gate_sweep_checker

Sequential stimulus-and-check stage for the gate-conversion blocks. It drives a combinational gate under test through every input combination in ascending order and waits a programmable settle time per vector. It samples the gate output and compares it against an expected truth table, then reports pass/fail, a mismatch count and the first failing vector. It sits directly upstream of the gate (its `dut_in` feeds the gate inputs) and directly downstream of it (it consumes `dut_y`). This replaces hand-written `#10` stimulus with a synthesizable, clocked sweep.

## Interface
- `N_IN`, default 2: number of gate inputs, 1..4.
- `SETTLE`, default 2: settle cycles per vector before sampling, ≥1.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `start`  in  1  begin sweep; accepted only in IDLE.
- `tt_expected`  in  2**N_IN  expected truth table; bit i is the expected `y` for `dut_in == i`.
- `dut_y`  in  1  gate-under-test output.
- `dut_in`  out  N_IN  gate inputs; MSB is the first operand (`a`), LSB is the last (`b`).
- `busy`  out  1  high from start acceptance until DONE is exited.
- `done`  out  1  one-cycle pulse at sweep end.
- `pass`  out  1  high when `err_count == 0`; valid from `done` until the next start.
- `err_count`  out  N_IN+1  mismatching vectors in the last sweep.
- `first_fail_vec`  out  N_IN  lowest failing vector index.
- `first_fail_valid`  out  1  `first_fail_vec` is meaningful.
- `observed_tt`  out  2**N_IN  sampled `dut_y` per vector.

## Operation
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: `busy`=0.
  - On `start`=1: latch `tt_expected` into `tt_q`.
  - Clear `vec`, `cnt`, `err_count`, `first_fail_valid`, `observed_tt`, `pass`.
  - Set `dut_in`=0 and go to SETTLE.
- SETTLE: `cnt` increments each cycle. When `cnt == SETTLE-1`, go to SAMPLE.
- SAMPLE: `observed_tt[vec] <= dut_y`.
  - If `dut_y != tt_q[vec]`: increment `err_count`. If `first_fail_valid`=0, set `first_fail_vec <= vec` and `first_fail_valid <= 1`.
  - If `vec == 2**N_IN-1`: go to DONE.
  - Otherwise: `vec++`, `dut_in <= vec+1`, `cnt <= 0`, go to SETTLE.
- DONE: `done`=1 for this one cycle, `pass <= (err_count_next == 0)`, go to IDLE. Results hold until the next accepted start.
- `start` while `busy` is ignored. `tt_expected` changes after acceptance have no effect.
- `err_count` is wide enough for 2**N_IN errors; no saturation is needed.
- `dut_in` is registered and changes only on SAMPLE→SETTLE transitions and at start.

## Timing
- Reset (`rst_n`=0 at an edge) puts every output at 0: `dut_in`, `busy`, `done`, `pass`, `err_count`, `first_fail_vec`, `first_fail_valid`, `observed_tt`. State returns to IDLE.
- Reset takes priority over `start` and over any mid-sweep state. A partial sweep is discarded, and no `done` pulse is produced.
- Start is accepted at edge k. `busy`=1 and `dut_in`=0 from k.
- Each vector occupies SETTLE+1 cycles, with the sample taken at the SAMPLE edge.
- `done` is high in the cycle beginning at edge k + 2**N_IN·(SETTLE+1). With the defaults (N_IN=2, SETTLE=2) this is k+12.
- `busy` falls together with `done`'s deassertion, one cycle after DONE.
- `start` asserted in the DONE cycle is ignored. `start` asserted in the following IDLE cycle is accepted.

## Structure
- Shared package `gate_chk_pkg` holds:
  - State encodings `ST_IDLE`=2'd0, `ST_SETTLE`=2'd1, `ST_SAMPLE`=2'd2, `ST_DONE`=2'd3.
  - Canonical 2-input truth tables `TT_AND`=4'b1000, `TT_NAND`=4'b0111, `TT_OR`=4'b1110, `TT_NOR`=4'b0001, `TT_XOR`=4'b0110.
- One sub-module, `settle_timer`: loadable up-counter with `clr`, `en` and an `expired` flag at SETTLE-1. The FSM, vector counter and compare logic stay in the top module.

## Test plan
- `and_gate_nand` as DUT, `tt_expected`=`TT_AND`, start at edge k → `dut_in` sweeps 0,1,2,3. `done` at k+12, `pass`=1, `err_count`=0, `observed_tt`=4'b1000.
- Same DUT with `tt_expected`=`TT_NAND` → `err_count`=4, `first_fail_vec`=0, `first_fail_valid`=1, `pass`=0.
- Behavioural model with `dut_y` stuck at 1, `tt_expected`=`TT_AND` → `err_count`=3, `first_fail_vec`=0, `observed_tt`=4'b1111.
- `rst_n`=0 for one cycle at k+6 → all outputs 0 at the next edge and no `done` pulse. A new start then completes normally 12 cycles later.
- `start` held high continuously → sweeps are accepted back-to-back with one IDLE cycle between `done` and the next acceptance. `start` pulses while busy are ignored.
- N_IN=3, SETTLE=1, 3-input AND model with tt=8'b1000_0000 → `done` at k+16, `pass`=1.
